ifu_fetch: RTL and testbench
============================

# ifu_fetch

Instruction fetch unit: the initiator side of the instruction-memory interface. Holds the PC, issues one fetch request at a time to the instruction ROM/memory, and accepts the variable-latency response. Buffers the fetched word and hands it to decode over a valid/ready handshake. Accepts PC redirects from execute and discards any in-flight fetch that a redirect makes stale.

## Interface
- RESET_PC, 32'h8000_0000, PC loaded on reset; the memory maps this address to word 0.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_req_valid  out  1  fetch request valid; forced 0 while rst=1.
- imem_req_ready  in  1  memory accepts the request.
- imem_req_addr  out  32  fetch address, always the current PC, 4-byte aligned.
- imem_rsp_valid  in  1  response word valid; one per accepted request.
- imem_rsp_data  in  32  instruction word.
- redirect_valid  in  1  one-cycle PC redirect (jump/branch taken).
- redirect_pc  in  32  redirect target; bits [1:0] ignored (treated as 0).
- inst_valid  out  1  instruction available to decode.
- inst_ready  in  1  decode accepts the instruction.
- inst_pc  out  32  PC of inst_data.
- inst_data  out  32  fetched instruction.

## Operation
- State machine (S_REQ, S_WAIT, S_OUT) plus registers pc, kill, inst_pc, inst_data.
- S_REQ: imem_req_valid=1, addr=pc. On req fire, go to S_WAIT. A redirect in the same cycle as the fire sets pc<=redirect_pc and kill<=1. A redirect without a fire sets pc<=redirect_pc and stays in S_REQ.
- S_WAIT: imem_req_valid=0.
  - On imem_rsp_valid with kill=0 and no redirect: latch inst_data<=rsp, inst_pc<=pc, pc<=pc+4, go to S_OUT.
  - On imem_rsp_valid with kill=1, or with a redirect in the same cycle: drop the response, clear kill, go to S_REQ. A same-cycle redirect also loads pc.
  - Redirect without a response: pc<=redirect_pc, kill<=1, stay in S_WAIT.
- S_OUT: inst_valid=1, outputs held stable until the handshake completes.
  - On inst_valid&inst_ready, go to S_REQ.
  - On a redirect, go to S_REQ with pc<=redirect_pc. Without a same-cycle handshake the held instruction is discarded. With one, decode is deemed to have consumed it.
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC+4 wraps to 0 with no error.
- At most one outstanding request. A response arriving outside S_WAIT is a protocol violation; assert it in simulation.

## Timing
- Reset values: state=S_REQ, pc=RESET_PC, kill=0, inst_valid=0, inst_pc=0, inst_data=0, imem_req_valid=0 during rst.
- First request is presented in the first cycle after rst deasserts.
- With zero-wait memory (req_ready=1, rsp one cycle after the fire) and inst_ready=1: request in cycle N, response in N+1, inst_valid in N+2, next request in N+3. Peak rate is one instruction per 3 cycles.
- Redirect to first request at the new PC: 1 cycle from S_REQ/S_OUT. From S_WAIT it takes memory latency plus 1.
- Reset asserted mid-fetch abandons the outstanding request. The memory side is reset in the same cycle, so no stale response may follow.
- Outputs come from registers/state only; no combinational path from redirect_valid or inst_ready to any output.

## Structure
- Shared package ifu_pkg: state enum, RESET_PC default, INST_W=32, ADDR_W=32.
- One sub-module, ifu_pc: PC register with reset load, +4 increment and redirect load (redirect priority over increment).

## Test plan
- Reset, then zero-wait memory returning 32'h0050_0313 at 0x8000_0000 with inst_ready=1: inst_valid in cycle 3 with inst_pc=0x8000_0000. Next request addr=0x8000_0004.
- inst_ready held 0 for 5 cycles: inst_valid, inst_pc and inst_data stay stable, no new request issues, and the fetch resumes 1 cycle after ready rises.
- Redirect to 0x8000_0100 in S_WAIT with 3-cycle latency: the stale response is dropped and inst_valid stays 0. The next request addr=0x8000_0100 and inst_pc=0x8000_0100.
- Redirect coincident with the response: the response is dropped and the next request addr equals redirect_pc. Redirect with redirect_pc=0x8000_0102 yields addr 0x8000_0100.
- imem_req_ready low for 4 cycles: req_valid and addr are held constant. Redirect during that window changes the addr to the target the next cycle.
- Redirect coincident with the S_OUT handshake: the instruction counts as consumed once, and the next request goes to the target. PC 0xFFFF_FFFC is followed by a fetch at 0x0000_0000.

Source files
------------

// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Widths, the default reset PC and the fetch FSM state encoding live here.
package ifu_pkg;

    localparam int INST_W = 32;
    localparam int ADDR_W = 32;

    localparam logic [ADDR_W-1:0] DEFAULT_RESET_PC = 32'h8000_0000;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_OUT  = 2'd2
    } state_e;

    // Instruction addresses are word aligned; low bits of any target are dropped.
    function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/ifu_fetch_if.sv
// Instruction-memory request/response channel between fetch (master) and memory (slave).
// One request in flight at a time; each accepted request yields one response beat.
interface ifu_fetch_if;
    import ifu_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              rsp_valid;
    logic [INST_W-1:0] rsp_data;

    modport master (
        output req_valid,
        output req_addr,
        input  req_ready,
        input  rsp_valid,
        input  rsp_data
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        output req_ready,
        output rsp_valid,
        output rsp_data
    );

endinterface

// File: rtl/ifu_pc.sv
// Program counter register: reset load, redirect load and sequential +4 step.
// A redirect always wins over the increment; arithmetic wraps modulo 2^32.
module ifu_pc
    import ifu_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_pc,
    input  logic              incr,
    output logic [ADDR_W-1:0] pc
);

    // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= align_pc(load_pc);
        end else if (incr) begin
            pc <= pc + ADDR_W'(4);
        end
    end

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: issues one fetch at a time, buffers the returned word
// for decode, and squashes any in-flight fetch made stale by a redirect.
module ifu_fetch
    import ifu_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic              clk,
    input  logic              rst,
    ifu_fetch_if.master       imem,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [ADDR_W-1:0] inst_pc,
    output logic [INST_W-1:0] inst_data
);

    state_e            state;
    state_e            state_next;
    logic              kill;
    logic              kill_next;
    logic              pc_incr;
    logic [ADDR_W-1:0] pc;

    ifu_pc #(
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk     (clk),
        .rst     (rst),
        .load    (redirect_valid),
        .load_pc (redirect_pc),
        .incr    (pc_incr),
        .pc      (pc)
    );

    // NOTE: every signal written here gets a default first, so no path infers a latch.
    always_comb begin
        state_next = state;
        kill_next  = kill;
        pc_incr    = 1'b0;

        unique case (state)
            S_REQ: begin
                if (imem.req_ready) begin
                    state_next = S_WAIT;
                    // A redirect alongside the fire means the word now in flight is stale.
                    kill_next  = redirect_valid;
                end
            end
            S_WAIT: begin
                if (imem.rsp_valid) begin
                    kill_next = 1'b0;
                    if (!kill && !redirect_valid) begin
                        pc_incr    = 1'b1;
                        state_next = S_OUT;
                    end else begin
                        state_next = S_REQ;
                    end
                end else if (redirect_valid) begin
                    kill_next = 1'b1;
                end
            end
            S_OUT: begin
                if (inst_ready || redirect_valid) begin
                    state_next = S_REQ;
                end
            end
            default: begin
                state_next = S_REQ;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_REQ;
            kill      <= 1'b0;
            inst_pc   <= '0;
            inst_data <= '0;
        end else begin
            state <= state_next;
            kill  <= kill_next;
            if (pc_incr) begin
                inst_pc   <= pc;
                inst_data <= imem.rsp_data;
            end
        end
    end

    // Outputs depend on registered state only (plus the reset gate on the request).
    assign imem.req_valid = (state == S_REQ) && !rst;
    assign imem.req_addr  = pc;
    assign inst_valid     = (state == S_OUT);

    // Memory may only answer while a request is outstanding.
    a_rsp_only_in_wait: assert property (
        @(posedge clk) disable iff (rst) imem.rsp_valid |-> (state == S_WAIT)
    );

endmodule

// File: tb/tb_ifu_fetch.sv
// Self-checking bench for ifu_fetch: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a transaction-level model.
module tb_ifu_fetch;
    import ifu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        inst_ready = 1'b1;
    logic        inst_valid;
    logic [31:0] inst_pc;
    logic [31:0] inst_data;

    int errors = 0;
    int checks = 0;
    int lat = 1;

    always #5 clk = ~clk;

    ifu_fetch_if imem ();

    ifu_fetch dut (
        .clk            (clk),
        .rst            (rst),
        .imem           (imem),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_pc        (inst_pc),
        .inst_data      (inst_data)
    );

    // Memory contents as a pure function of address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h8000_0000) return 32'h0050_0313;
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Memory: capture each accepted request, answer after 'lat' cycles.
    initial begin
        int          cnt;
        logic [31:0] addr;
        cnt = 0;
        addr = 32'h0;
        imem.rsp_valid = 1'b0;
        imem.rsp_data  = 32'h0;
        forever begin
            @(posedge clk);
            if (rst) cnt = 0;
            else if (imem.req_valid && imem.req_ready) begin
                cnt  = lat;
                addr = imem.req_addr;
            end
            @(negedge clk);
            #1;
            if (!rst && cnt > 0) begin
                cnt = cnt - 1;
                imem.rsp_valid = (cnt == 0);
                imem.rsp_data  = (cnt == 0) ? mem_word(addr) : 32'hDEAD_BEEF;
            end else begin
                imem.rsp_valid = 1'b0;
                imem.rsp_data  = 32'hDEAD_BEEF;
            end
        end
    end

    // Transaction-level model: next fetch address, one outstanding fetch that a
    // redirect can mark stale, and one buffered instruction awaiting decode.
    bit          m_out = 1'b0;
    bit          m_stale = 1'b0;
    bit          m_pend = 1'b0;
    logic [31:0] m_pc = DEFAULT_RESET_PC;
    logic [31:0] m_addr = 32'h0;
    logic [31:0] m_ipc = 32'h0;
    logic [31:0] m_idata = 32'h0;

    task automatic model_step();
        if (rst) begin
            m_out = 0; m_stale = 0; m_pend = 0; m_pc = DEFAULT_RESET_PC;
        end else begin
            if (m_pend) begin
                if (inst_ready || redirect_valid) m_pend = 0;
            end else if (m_out) begin
                if (imem.rsp_valid) begin
                    if (!m_stale && !redirect_valid) begin
                        m_pend  = 1;
                        m_ipc   = m_addr;
                        m_idata = mem_word(m_addr);
                        m_pc    = m_addr + 32'd4;
                    end
                    m_out = 0;
                end else if (redirect_valid) begin
                    m_stale = 1;
                end
            end else if (imem.req_ready) begin
                m_out   = 1;
                m_addr  = m_pc;
                m_stale = redirect_valid;
            end
            if (redirect_valid) m_pc = {redirect_pc[31:2], 2'b00};
        end
    endtask

    task automatic compare();
        if (rst) begin
            check("req_valid_in_reset", 32'(imem.req_valid), 32'd0);
        end else begin
            check("req_valid", 32'(imem.req_valid), 32'(!m_out && !m_pend));
            if (!m_out && !m_pend) check("req_addr", imem.req_addr, m_pc);
            check("inst_valid", 32'(inst_valid), 32'(m_pend));
            if (m_pend) begin
                check("inst_pc", inst_pc, m_ipc);
                check("inst_data", inst_data, m_idata);
            end
        end
    endtask

    // One cycle: model sees the edge, outputs compared mid-low-phase, then inputs may change.
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare();
        #1;
    endtask

    initial begin
        imem.req_ready = 1'b1;
        repeat (3) tick();
        check("rst_inst_valid", 32'(inst_valid), 32'd0);
        check("rst_inst_pc", inst_pc, 32'h0);
        check("rst_inst_data", inst_data, 32'h0);
        check("rst_req_valid", 32'(imem.req_valid), 32'd0);

        // First fetch with zero-wait memory.
        rst = 1'b0;
        #1;
        check("first_req_valid", 32'(imem.req_valid), 32'd1);
        check("first_req_addr", imem.req_addr, 32'h8000_0000);
        tick();
        check("first_no_inst_yet", 32'(inst_valid), 32'd0);
        tick();
        check("first_inst_valid", 32'(inst_valid), 32'd1);
        check("first_inst_pc", inst_pc, 32'h8000_0000);
        check("first_inst_data", inst_data, 32'h0050_0313);
        tick();
        check("second_req_valid", 32'(imem.req_valid), 32'd1);
        check("second_req_addr", imem.req_addr, 32'h8000_0004);

        // Decode stalls for 5 cycles.
        inst_ready = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            check("stall_inst_valid", 32'(inst_valid), 32'd1);
            check("stall_inst_pc", inst_pc, 32'h8000_0004);
            check("stall_inst_data", inst_data, mem_word(32'h8000_0004));
            check("stall_no_req", 32'(imem.req_valid), 32'd0);
            if (i < 4) tick();
        end
        inst_ready = 1'b1;
        tick();
        check("resume_req_valid", 32'(imem.req_valid), 32'd1);
        check("resume_req_addr", imem.req_addr, 32'h8000_0008);

        // Redirect while waiting on a 3-cycle response.
        lat = 3;
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0100;
        tick();
        redirect_valid = 1'b0;
        check("wait_rdr_no_inst0", 32'(inst_valid), 32'd0);
        tick();
        check("wait_rdr_no_inst1", 32'(inst_valid), 32'd0);
        tick();
        check("wait_rdr_no_inst2", 32'(inst_valid), 32'd0);
        check("wait_rdr_req_valid", 32'(imem.req_valid), 32'd1);
        check("wait_rdr_req_addr", imem.req_addr, 32'h8000_0100);
        lat = 1;
        tick();
        tick();
        check("wait_rdr_inst_valid", 32'(inst_valid), 32'd1);
        check("wait_rdr_inst_pc", inst_pc, 32'h8000_0100);

        // Redirect coincident with the response, unaligned target.
        tick();
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0102;
        tick();
        redirect_valid = 1'b0;
        check("rsp_rdr_req_valid", 32'(imem.req_valid), 32'd1);
        check("rsp_rdr_req_addr", imem.req_addr, 32'h8000_0100);
        check("rsp_rdr_no_inst", 32'(inst_valid), 32'd0);

        // Memory back-pressure with a redirect inside the window.
        tick();
        tick();
        imem.req_ready = 1'b0;
        tick();
        check("bp_addr0", imem.req_addr, 32'h8000_0104);
        tick();
        check("bp_valid1", 32'(imem.req_valid), 32'd1);
        check("bp_addr1", imem.req_addr, 32'h8000_0104);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0200;
        tick();
        redirect_valid = 1'b0;
        check("bp_rdr_valid", 32'(imem.req_valid), 32'd1);
        check("bp_rdr_addr", imem.req_addr, 32'h8000_0200);
        tick();
        check("bp_rdr_addr_hold", imem.req_addr, 32'h8000_0200);
        imem.req_ready = 1'b1;
        tick();
        tick();
        check("bp_inst_pc", inst_pc, 32'h8000_0200);

        // Redirect together with the decode handshake, then wrap past 0xFFFF_FFFC.
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        check("hs_rdr_no_replay", 32'(inst_valid), 32'd0);
        check("hs_rdr_req_addr", imem.req_addr, 32'hFFFF_FFFC);
        tick();
        tick();
        check("wrap_inst_pc", inst_pc, 32'hFFFF_FFFC);
        tick();
        check("wrap_req_valid", 32'(imem.req_valid), 32'd1);
        check("wrap_req_addr", imem.req_addr, 32'h0000_0000);

        // Randomized traffic, including occasional mid-fetch resets.
        for (int i = 0; i < 4000; i++) begin
            imem.req_ready = ($urandom_range(3) != 0);
            inst_ready     = ($urandom_range(9) < 7);
            redirect_valid = ($urandom_range(11) == 0);
            redirect_pc    = ($urandom_range(5) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15)))
                                                      : $urandom;
            lat            = $urandom_range(1, 4);
            rst            = ((i % 800) == 400) || ((i % 800) == 401);
            tick();
        end
        rst = 1'b0;
        redirect_valid = 1'b0;
        repeat (10) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
